// File: rtl/crc16_arbiter_engine_if.sv
// rtl/crc16_arbiter_engine_if.sv - seal/CPU request and CRC result bundle for crc16_arbiter_engine
interface crc16_arbiter_engine_if;
  logic        seal_init;
  logic        seal_feed;
  logic [7:0]  seal_byte;
  logic        cpu_data_wr;
  logic        cpu_ctrl_wr;
  logic [7:0]  cpu_wdata;
  logic        crc_busy;
  logic [15:0] crc_value;
  logic [31:0] cpu_rdata;

  modport master (
    output seal_init, seal_feed, seal_byte, cpu_data_wr, cpu_ctrl_wr, cpu_wdata,
    input  crc_busy, crc_value, cpu_rdata
  );

  modport slave (
    input  seal_init, seal_feed, seal_byte, cpu_data_wr, cpu_ctrl_wr, cpu_wdata,
    output crc_busy, crc_value, cpu_rdata
  );
endinterface

// File: rtl/crc16_arbiter_engine.sv
// rtl/crc16_arbiter_engine.sv - shared CRC-16/CCITT-FALSE engine, seal port over CPU port
// CRC16_FAST_EN: process a whole byte in the accept cycle instead of the 8-cycle bit-serial SHIFT.
module crc16_arbiter_engine #(
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] INIT = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  crc16_arbiter_engine_if.slave  bus
);

  logic        init_req;
  logic        clr_req;
  logic        set_ovr;
  logic        set_drop;
  logic [15:0] crc_q, crc_d;
  logic        ovr_q, ovr_d;
  logic        drop_q, drop_d;

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic d);
    logic fb;
    fb = c[15] ^ d;
    return {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  endfunction

  assign init_req = bus.seal_init | (bus.cpu_ctrl_wr & bus.cpu_wdata[0]);
  assign clr_req  = bus.cpu_ctrl_wr & bus.cpu_wdata[1];

`ifdef CRC16_FAST_EN

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = crc_bit(r, b[i]);
    end
    return r;
  endfunction

  always_comb begin
    crc_d    = crc_q;
    set_ovr  = 1'b0;
    set_drop = 1'b0;
    if (init_req) begin
      crc_d    = INIT;
      set_ovr  = bus.seal_feed;
      set_drop = bus.cpu_data_wr;
    end else if (bus.seal_feed) begin
      crc_d    = crc_byte(crc_q, bus.seal_byte);
      set_drop = bus.cpu_data_wr;
    end else if (bus.cpu_data_wr) begin
      crc_d    = crc_byte(crc_q, bus.cpu_wdata);
    end
  end

  assign bus.crc_busy = bus.seal_feed | bus.cpu_data_wr;

`else

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Init outranks everything, including a SHIFT in flight; feeds lose to init or to SHIFT.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    set_ovr  = 1'b0;
    set_drop = 1'b0;
    if (init_req) begin
      crc_d    = INIT;
      state_d  = IDLE;
      set_ovr  = bus.seal_feed;
      set_drop = bus.cpu_data_wr;
    end else if (state_q == SHIFT) begin
      crc_d    = crc_bit(crc_q, data_q[7]);
      data_d   = {data_q[6:0], 1'b0};
      cnt_d    = cnt_q + 3'd1;
      set_ovr  = bus.seal_feed;
      set_drop = bus.cpu_data_wr;
      if (cnt_q == 3'd7) begin
        state_d = IDLE;
      end
    end else if (bus.seal_feed) begin
      data_d   = bus.seal_byte;
      cnt_d    = 3'd0;
      state_d  = SHIFT;
      set_drop = bus.cpu_data_wr;
    end else if (bus.cpu_data_wr) begin
      data_d   = bus.cpu_wdata;
      cnt_d    = 3'd0;
      state_d  = SHIFT;
    end
  end

  // Feed inputs are folded in so the sequencer sees busy at the edge closing its feed cycle.
  assign bus.crc_busy = (state_q == SHIFT) | bus.seal_feed | bus.cpu_data_wr;

`endif

  always_comb begin
    ovr_d  = (ovr_q  & ~clr_req) | set_ovr;
    drop_d = (drop_q & ~clr_req) | set_drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q  <= INIT;
      ovr_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      crc_q  <= crc_d;
      ovr_q  <= ovr_d;
      drop_q <= drop_d;
    end
  end

  assign bus.crc_value = crc_q;
  assign bus.cpu_rdata = {13'b0, ovr_q, drop_q, bus.crc_busy, crc_q};

endmodule

// File: tb/tb_crc16_arbiter_engine.sv
// tb/tb_crc16_arbiter_engine.sv - directed bench with byte-level reference model for crc16_arbiter_engine
module tb_crc16_arbiter_engine;

`ifdef CRC16_FAST_EN
  localparam int SHIFT_CYC = 0;
  localparam int BUSY_CYC  = 1;
`else
  localparam int SHIFT_CYC = 8;
  localparam int BUSY_CYC  = 9;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  crc16_arbiter_engine_if bus ();

  crc16_arbiter_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-byte CRC plus a count of cycles the engine stays occupied.
  logic [15:0] m_crc;
  int          m_left;
  logic        m_ovr, m_drop;

  function automatic logic [15:0] m_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic init, clr, so, sd;
    if (rst) begin
      m_crc  = 16'hFFFF;
      m_left = 0;
      m_ovr  = 1'b0;
      m_drop = 1'b0;
    end else begin
      init = bus.seal_init | (bus.cpu_ctrl_wr & bus.cpu_wdata[0]);
      clr  = bus.cpu_ctrl_wr & bus.cpu_wdata[1];
      so   = 1'b0;
      sd   = 1'b0;
      if (init) begin
        m_crc  = 16'hFFFF;
        m_left = 0;
        so     = bus.seal_feed;
        sd     = bus.cpu_data_wr;
      end else if (m_left > 0) begin
        m_left = m_left - 1;
        so     = bus.seal_feed;
        sd     = bus.cpu_data_wr;
      end else if (bus.seal_feed) begin
        m_crc  = m_byte(m_crc, bus.seal_byte);
        m_left = SHIFT_CYC;
        sd     = bus.cpu_data_wr;
      end else if (bus.cpu_data_wr) begin
        m_crc  = m_byte(m_crc, bus.cpu_wdata);
        m_left = SHIFT_CYC;
      end
      m_ovr  = (m_ovr  & ~clr) | so;
      m_drop = (m_drop & ~clr) | sd;
    end
  end

  always @(negedge clk) begin
    logic exp_busy;
    if (!rst) begin
      exp_busy = (m_left > 0) | bus.seal_feed | bus.cpu_data_wr;
      check("busy_vs_model", {31'b0, bus.crc_busy}, {31'b0, exp_busy});
      check("flags_vs_model", {30'b0, bus.cpu_rdata[18:17]}, {30'b0, m_ovr, m_drop});
      if (!exp_busy) begin
        check("rdata_vs_model", bus.cpu_rdata, {13'b0, m_ovr, m_drop, 1'b0, m_crc});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic seal_pulse(input logic [7:0] b);
    bus.seal_feed = 1'b1;
    bus.seal_byte = b;
    cyc();
    bus.seal_feed = 1'b0;
  endtask

  task automatic cpu_ctrl(input logic [7:0] w);
    bus.cpu_ctrl_wr = 1'b1;
    bus.cpu_wdata   = w;
    cyc();
    bus.cpu_ctrl_wr = 1'b0;
  endtask

  task automatic seal_init_pulse();
    bus.seal_init = 1'b1;
    cyc();
    bus.seal_init = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.crc_busy && n < 20) begin
      cyc();
      n++;
    end
    if (bus.crc_busy) begin
      check("wait_idle_timeout", 32'd1, 32'd0);
    end
  endtask

  task automatic seal_string_123456789();
    logic [7:0] s [9];
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int i = 0; i < 9; i++) begin
      seal_pulse(s[i]);
      wait_idle();
    end
  endtask

  initial begin
    int busy_cnt;
    rst             = 1'b1;
    bus.seal_init   = 1'b0;
    bus.seal_feed   = 1'b0;
    bus.seal_byte   = 8'h00;
    bus.cpu_data_wr = 1'b0;
    bus.cpu_ctrl_wr = 1'b0;
    bus.cpu_wdata   = 8'h00;
    #12;
    rst = 1'b0;
    cyc();

    check("reset_crc", {16'h0, bus.crc_value}, 32'h0000_FFFF);
    check("reset_busy", {31'b0, bus.crc_busy}, 32'd0);
    check("reset_rdata", bus.cpu_rdata, 32'h0000_FFFF);

    // Single zero byte: busy window length and result.
    bus.seal_feed = 1'b1;
    bus.seal_byte = 8'h00;
    #1;
    busy_cnt = bus.crc_busy ? 1 : 0;
    @(posedge clk);
    #1;
    bus.seal_feed = 1'b0;
    #1;
    while (bus.crc_busy && busy_cnt < 30) begin
      busy_cnt++;
      cyc();
      #1;
    end
    check("busy_cycles", busy_cnt, BUSY_CYC);
    check("crc_zero_byte", {16'h0, bus.crc_value}, 32'h0000_E1F0);
    check("model_zero_byte", {16'h0, m_crc}, 32'h0000_E1F0);
    cyc();

    // Check value over "123456789".
    seal_init_pulse();
    seal_string_123456789();
    check("crc_check_string", {16'h0, bus.crc_value}, 32'h0000_29B1);
    check("model_check_string", {16'h0, m_crc}, 32'h0000_29B1);
    check("flags_after_string", {30'b0, bus.cpu_rdata[18:17]}, 32'd0);

    // Seal and CPU feed together: seal wins, CPU byte dropped.
    seal_init_pulse();
    bus.cpu_data_wr = 1'b1;
    bus.cpu_wdata   = 8'hAA;
    seal_pulse(8'h31);
    bus.cpu_data_wr = 1'b0;
    wait_idle();
    check("crc_collision", {16'h0, bus.crc_value}, 32'h0000_C782);
    check("cpu_dropped_set", {31'b0, bus.cpu_rdata[17]}, 32'd1);
    cpu_ctrl(8'h02);
    check("cpu_dropped_clear", {31'b0, bus.cpu_rdata[17]}, 32'd0);

    // CPU-only feed path.
    cpu_ctrl(8'h01);
    bus.cpu_data_wr = 1'b1;
    bus.cpu_wdata   = 8'h31;
    cyc();
    bus.cpu_data_wr = 1'b0;
    wait_idle();
    check("crc_cpu_feed", {16'h0, bus.crc_value}, 32'h0000_C782);

`ifndef CRC16_FAST_EN
    // CPU feed during SHIFT is dropped and leaves the byte intact.
    seal_init_pulse();
    seal_pulse(8'h31);
    cyc();
    cyc();
    bus.cpu_data_wr = 1'b1;
    bus.cpu_wdata   = 8'h55;
    cyc();
    bus.cpu_data_wr = 1'b0;
    wait_idle();
    check("crc_after_cpu_drop", {16'h0, bus.crc_value}, 32'h0000_C782);
    check("cpu_dropped_mid_shift", {31'b0, bus.cpu_rdata[17]}, 32'd1);
    cpu_ctrl(8'h02);

    // Seal feed during SHIFT raises overrun.
    seal_pulse(8'h31);
    cyc();
    seal_pulse(8'h77);
    wait_idle();
    check("seal_overrun_set", {31'b0, bus.cpu_rdata[18]}, 32'd1);
    check("cpu_dropped_stays_clear", {31'b0, bus.cpu_rdata[17]}, 32'd0);
    cpu_ctrl(8'h02);

    // CPU init at cycle 4 of SHIFT aborts the byte.
    seal_init_pulse();
    seal_pulse(8'h31);
    cyc();
    cyc();
    cyc();
    cpu_ctrl(8'h01);
    check("abort_crc", {16'h0, bus.crc_value}, 32'h0000_FFFF);
    check("abort_busy", {31'b0, bus.crc_busy}, 32'd0);
    seal_string_123456789();
    check("crc_after_abort", {16'h0, bus.crc_value}, 32'h0000_29B1);
`endif

    // Asynchronous reset in the middle of a byte.
    seal_pulse(8'h5A);
    cyc();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_crc", {16'h0, bus.crc_value}, 32'h0000_FFFF);
    check("async_rst_busy", {31'b0, bus.crc_busy}, 32'd0);
    check("async_rst_rdata", bus.cpu_rdata, 32'h0000_FFFF);
    rst = 1'b0;
    cyc();
    cyc();
    check("post_rst_rdata", bus.cpu_rdata, 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
